// File: rtl/adc_5g_phase_cal_if.sv
// Control/status bundle between the DCM phase calibrator and the ADC capture interface.
// The calibrator is the master; the ADC interface / DCM side is the slave.
interface adc_5g_phase_cal_if;
  logic       cal_start;
  logic       dcm_locked;
  logic       dcm_psdone;
  logic       samp_valid;
  logic [3:0] samp_sync;
  logic       dcm_reset;
  logic       dcm_psen;
  logic       dcm_psincdec;
  logic       cal_busy;
  logic       cal_done;
  logic       cal_fail;
  logic [1:0] cal_fail_code;
  logic [7:0] cal_best_start;
  logic [7:0] cal_best_len;

  modport master (
    input  cal_start, dcm_locked, dcm_psdone, samp_valid, samp_sync,
    output dcm_reset, dcm_psen, dcm_psincdec, cal_busy, cal_done, cal_fail,
           cal_fail_code, cal_best_start, cal_best_len
  );

  modport slave (
    output cal_start, dcm_locked, dcm_psdone, samp_valid, samp_sync,
    input  dcm_reset, dcm_psen, dcm_psincdec, cal_busy, cal_done, cal_fail,
           cal_fail_code, cal_best_start, cal_best_len
  );
endinterface

// File: rtl/adc_5g_phase_cal.sv
// DCM phase calibration sequencer: reset DCM, wait for lock, sweep the phase, score the
// four-phase sync capture at each point and park at the centre of the longest clean run.
module adc_5g_phase_cal #(
  parameter int STEP_COUNT = 64,
  parameter int WINDOW     = 1024,
  parameter int RST_CYCLES = 16,
  parameter int TIMEOUT    = 65535
) (
  input  logic                ctrl_clk,
  input  logic                ctrl_reset,
  adc_5g_phase_cal_if.master  bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(WINDOW + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [7:0]    LAST     = 8'(STEP_COUNT - 1);
  localparam logic [7:0]    HALF     = 8'(STEP_COUNT / 2);

  typedef enum logic [3:0] {
    S_IDLE, S_DCM_RST, S_WAIT_LOCK, S_PRE_DEC, S_MEASURE,
    S_STEP_INC, S_CENTER_DEC, S_DONE, S_FAIL
  } state_t;

  state_t        r_state;
  logic [RW-1:0] r_rcnt;
  logic [TW-1:0] r_tmo;
  logic [CW-1:0] r_scnt;
  logic          r_bad;
  logic [7:0]    r_idx, r_cur_start, r_cur_len, r_best_start, r_best_len, r_rem;
  logic          r_ps_wait;
  logic          r_dcm_reset, r_psen, r_psincdec, r_busy, r_done, r_fail;
  logic [1:0]    r_code;

  logic       w_samp_bad, w_pt_good, w_better, w_lock_lost;
  logic [7:0] w_cur_start_nx, w_cur_len_nx, w_best_start_nx, w_best_len_nx;
  logic [7:0] w_target, w_center_rem;

  // Scoring of the point that closes in this cycle (only consumed on the last sample).
  always_comb begin
    w_samp_bad      = bus.samp_valid && (bus.samp_sync != 4'h0) && (bus.samp_sync != 4'hF);
    w_pt_good       = !(r_bad || w_samp_bad);
    w_cur_start_nx  = (r_cur_len == 8'd0) ? r_idx : r_cur_start;
    w_cur_len_nx    = w_pt_good ? (r_cur_len + 8'd1) : 8'd0;
    w_better        = w_pt_good && (w_cur_len_nx > r_best_len);
    w_best_start_nx = w_better ? w_cur_start_nx : r_best_start;
    w_best_len_nx   = w_better ? w_cur_len_nx : r_best_len;
    w_target        = w_best_start_nx + (w_best_len_nx >> 1);
    w_center_rem    = LAST - w_target;
    w_lock_lost     = !bus.dcm_locked &&
                      ((r_state == S_PRE_DEC) || (r_state == S_MEASURE) ||
                       (r_state == S_STEP_INC) || (r_state == S_CENTER_DEC));
  end

  always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      r_state      <= S_IDLE;
      r_rcnt       <= '0;
      r_tmo        <= '0;
      r_scnt       <= '0;
      r_bad        <= 1'b0;
      r_idx        <= '0;
      r_cur_start  <= '0;
      r_cur_len    <= '0;
      r_best_start <= '0;
      r_best_len   <= '0;
      r_rem        <= '0;
      r_ps_wait    <= 1'b0;
      r_dcm_reset  <= 1'b0;
      r_psen       <= 1'b0;
      r_psincdec   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
      r_code       <= '0;
    end else begin
      r_psen <= 1'b0;
      if (w_lock_lost) begin
        r_state   <= S_FAIL;
        r_fail    <= 1'b1;
        r_busy    <= 1'b0;
        r_code    <= 2'b01;
        r_ps_wait <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE, S_FAIL: begin
            if (bus.cal_start) begin
              r_state      <= S_DCM_RST;
              r_dcm_reset  <= 1'b1;
              r_busy       <= 1'b1;
              r_done       <= 1'b0;
              r_fail       <= 1'b0;
              r_code       <= '0;
              r_best_start <= '0;
              r_best_len   <= '0;
              r_cur_start  <= '0;
              r_cur_len    <= '0;
              r_idx        <= '0;
              r_rcnt       <= '0;
              r_ps_wait    <= 1'b0;
            end
          end
          S_DCM_RST: begin
            if (r_rcnt == RST_LAST) begin
              r_dcm_reset <= 1'b0;
              r_state     <= S_WAIT_LOCK;
              r_tmo       <= '0;
            end else begin
              r_rcnt <= r_rcnt + 1'b1;
            end
          end
          S_WAIT_LOCK: begin
            if (bus.dcm_locked) begin
              r_state <= S_PRE_DEC;
              r_rem   <= HALF;
              r_tmo   <= '0;
            end else if (r_tmo == TMO_LAST) begin
              r_state <= S_FAIL;
              r_fail  <= 1'b1;
              r_busy  <= 1'b0;
              r_code  <= 2'b01;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
          // Shared phase-step engine: one psen per outstanding step, each gated by psdone.
          S_PRE_DEC, S_STEP_INC, S_CENTER_DEC: begin
            if (r_ps_wait) begin
              if (bus.dcm_psdone) begin
                r_ps_wait <= 1'b0;
                r_rem     <= r_rem - 8'd1;
                r_tmo     <= '0;
              end else if (r_tmo == TMO_LAST) begin
                r_state   <= S_FAIL;
                r_fail    <= 1'b1;
                r_busy    <= 1'b0;
                r_code    <= 2'b10;
                r_ps_wait <= 1'b0;
              end else begin
                r_tmo <= r_tmo + 1'b1;
              end
            end else if (r_rem != 8'd0) begin
              r_psen     <= 1'b1;
              r_psincdec <= (r_state == S_STEP_INC);
              r_ps_wait  <= 1'b1;
              r_tmo      <= '0;
            end else if (r_state == S_CENTER_DEC) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              if (r_state == S_STEP_INC) r_idx <= r_idx + 8'd1;
              r_state <= S_MEASURE;
              r_scnt  <= '0;
              r_bad   <= 1'b0;
              r_tmo   <= '0;
            end
          end
          S_MEASURE: begin
            if (bus.samp_valid) begin
              if (r_scnt == WIN_LAST) begin
                if (w_pt_good) r_cur_start <= w_cur_start_nx;
                r_cur_len    <= w_cur_len_nx;
                r_best_start <= w_best_start_nx;
                r_best_len   <= w_best_len_nx;
                r_tmo        <= '0;
                if (r_idx < LAST) begin
                  r_state <= S_STEP_INC;
                  r_rem   <= 8'd1;
                end else if (w_best_len_nx == 8'd0) begin
                  r_state <= S_FAIL;
                  r_fail  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_code  <= 2'b11;
                end else begin
                  r_state <= S_CENTER_DEC;
                  r_rem   <= w_center_rem;
                end
              end else begin
                r_scnt <= r_scnt + 1'b1;
                r_bad  <= r_bad | w_samp_bad;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.dcm_reset      = r_dcm_reset;
  assign bus.dcm_psen       = r_psen;
  assign bus.dcm_psincdec   = r_psincdec;
  assign bus.cal_busy       = r_busy;
  assign bus.cal_done       = r_done;
  assign bus.cal_fail       = r_fail;
  assign bus.cal_fail_code  = r_code;
  assign bus.cal_best_start = r_best_start;
  assign bus.cal_best_len   = r_best_len;
endmodule

// File: tb/tb_adc_5g_phase_cal.sv
// Scoreboard bench for adc_5g_phase_cal: a DCM/ADC model answers phase steps and feeds
// sync samples from a per-point good mask; a monitor checks each calibration outcome.
module tb_adc_5g_phase_cal;
  localparam int STEPS = 16;
  localparam int WIN   = 8;
  localparam int RSTC  = 4;
  localparam int TMO   = 100;

  logic clk = 1'b0;
  logic ctrl_reset;
  always #5 clk = ~clk;

  adc_5g_phase_cal_if bus();

  adc_5g_phase_cal #(
    .STEP_COUNT(STEPS), .WINDOW(WIN), .RST_CYCLES(RSTC), .TIMEOUT(TMO)
  ) dut (
    .ctrl_clk   (clk),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  typedef struct {
    int done; int fail; int code; int bstart; int blen; int inc; int dec;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] good_mask    = '0;
  logic        lock_en      = 1'b1;
  logic        withhold     = 1'b0;
  logic        force_unlock = 1'b0;

  int n_inc = 0, n_dec = 0, run_pulses = 0, tot_psen = 0;
  int pd_del = 0, lk_cnt = 0, cyc = 0;
  logic prev_end = 1'b0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
  endtask

  task automatic push_exp(input int d, input int f, input int code, input int bs,
                          input int bl, input int inc, input int dec);
    exp_t e;
    e.done = d; e.fail = f; e.code = code; e.bstart = bs; e.blen = bl;
    e.inc = inc; e.dec = dec;
    q.push_back(e);
  endtask

  // DCM + ADC model and end-of-calibration monitor, evaluated away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    logic end_now;
    cyc++;
    if (bus.cal_start && !bus.cal_busy) begin
      n_inc = 0; n_dec = 0; run_pulses = 0; pd_del = 0;
    end
    bus.dcm_psdone = 1'b0;
    if (pd_del > 0) begin
      pd_del--;
      if (pd_del == 0) bus.dcm_psdone = 1'b1;
    end
    if (bus.dcm_psen) begin
      tot_psen++;
      run_pulses++;
      if (bus.dcm_psincdec) n_inc++; else n_dec++;
      if (!(withhold && run_pulses == 3)) pd_del = 2;
    end
    if (bus.dcm_reset) lk_cnt = 3;
    else if (lk_cnt > 0) lk_cnt--;
    bus.dcm_locked = lock_en && !force_unlock && !bus.dcm_reset && (lk_cnt == 0);

    bus.samp_valid = (cyc % 3) != 0;
    if (!bus.samp_valid)                   bus.samp_sync = 4'b0110;
    else if (n_inc < 16 && good_mask[n_inc]) bus.samp_sync = cyc[0] ? 4'hF : 4'h0;
    else                                   bus.samp_sync = ((cyc % 4) == 0) ? 4'b0100 : 4'hF;

    end_now = bus.cal_done | bus.cal_fail;
    if (end_now && !prev_end) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_end: got done=%0d fail=%0d expected no completion",
                 bus.cal_done, bus.cal_fail);
      end else begin
        e = q.pop_front();
        chk("done",       int'(bus.cal_done),       e.done);
        chk("fail",       int'(bus.cal_fail),       e.fail);
        chk("fail_code",  int'(bus.cal_fail_code),  e.code);
        chk("best_start", int'(bus.cal_best_start), e.bstart);
        chk("best_len",   int'(bus.cal_best_len),   e.blen);
        chk("busy_end",   int'(bus.cal_busy),       0);
        chk("inc_pulses", n_inc,                    e.inc);
        chk("dec_pulses", n_dec,                    e.dec);
      end
    end
    prev_end = end_now;
  end

  task automatic start_cal();
    @(posedge clk); #1 bus.cal_start = 1'b1;
    @(posedge clk); #1 bus.cal_start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int k = 0; k < 3000 && q.size() != 0; k++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL %s_timeout: got %0d pending results expected 0", nm, q.size());
      q.delete();
    end
  endtask

  task automatic wait_inc(input int n);
    for (int k = 0; k < 2000 && n_inc < n; k++) begin @(posedge clk); #1; end
  endtask

  initial begin
    int t;
    int psen_snap;
    bus.cal_start = 1'b0;
    ctrl_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 ctrl_reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_dcm_reset", int'(bus.dcm_reset),      0);
    chk("rst_psen",      int'(bus.dcm_psen),       0);
    chk("rst_psincdec",  int'(bus.dcm_psincdec),   0);
    chk("rst_busy",      int'(bus.cal_busy),       0);
    chk("rst_done",      int'(bus.cal_done),       0);
    chk("rst_fail",      int'(bus.cal_fail),       0);
    chk("rst_code",      int'(bus.cal_fail_code),  0);
    chk("rst_bstart",    int'(bus.cal_best_start), 0);
    chk("rst_blen",      int'(bus.cal_best_len),   0);

    // Run at 4..9: centre 7, 15-7 = 8 final decrements.
    good_mask = 16'h03F0;
    push_exp(1, 0, 0, 4, 6, 15, 16);
    start_cal();
    chk("start_dcm_reset", int'(bus.dcm_reset), 1);
    chk("start_busy",      int'(bus.cal_busy),  1);
    t = 0;
    while (bus.dcm_reset && t < 50) begin t++; @(posedge clk); #1; end
    chk("dcm_reset_width", t, RSTC);
    wait_done("run_4_9");

    // Two runs of 3: earliest kept; centre 3, 12 final decrements. Mid-run start ignored.
    good_mask = 16'h1C1C;
    push_exp(1, 0, 0, 2, 3, 15, 20);
    start_cal();
    wait_inc(3);
    repeat (5) @(posedge clk);
    #1 bus.cal_start = 1'b1;
    @(posedge clk); #1 bus.cal_start = 1'b0;
    chk("ignored_start_reset", int'(bus.dcm_reset), 0);
    chk("ignored_start_busy",  int'(bus.cal_busy),  1);
    wait_done("two_runs");

    // No good point.
    good_mask = 16'h0000;
    push_exp(0, 1, 3, 0, 0, 15, 8);
    start_cal();
    wait_done("all_bad");

    // Lock never arrives: fail exactly TMO cycles after WAIT_LOCK entry, no psen.
    lock_en = 1'b0;
    push_exp(0, 1, 1, 0, 0, 0, 0);
    start_cal();
    t = 0;
    while (bus.dcm_reset && t < 50) begin t++; @(posedge clk); #1; end
    t = 0;
    while (!bus.cal_fail && t < 300) begin @(posedge clk); #1; t++; end
    chk("lock_timeout_cycles", t, TMO);
    wait_done("lock_timeout");
    lock_en = 1'b1;

    // Third psdone withheld.
    good_mask = 16'hFFFF;
    withhold  = 1'b1;
    push_exp(0, 1, 2, 0, 0, 0, 3);
    start_cal();
    wait_done("psdone_timeout");
    withhold = 1'b0;

    // Lock drops while measuring point 5: points 0..4 already scored.
    push_exp(0, 1, 1, 0, 5, 5, 8);
    start_cal();
    wait_inc(5);
    repeat (6) @(posedge clk);
    #1 force_unlock = 1'b1;
    @(posedge clk); #1;
    chk("lock_loss_fail", int'(bus.cal_fail),      1);
    chk("lock_loss_code", int'(bus.cal_fail_code), 1);
    wait_done("lock_loss");
    force_unlock = 1'b0;

    // Restart from FAIL: run at 9..11, centre 10, 5 final decrements.
    good_mask = 16'h0E00;
    push_exp(1, 0, 0, 9, 3, 15, 13);
    start_cal();
    wait_done("rerun_after_fail");

    // Asynchronous reset while an increment pulse is on the bus.
    good_mask = 16'h03F0;
    start_cal();
    t = 0;
    while (!(bus.dcm_psen && bus.dcm_psincdec) && t < 2000) begin @(posedge clk); #1; t++; end
    chk("saw_inc_pulse", int'(bus.dcm_psen && bus.dcm_psincdec), 1);
    ctrl_reset = 1'b1;
    #1;
    chk("midrst_psen",     int'(bus.dcm_psen),       0);
    chk("midrst_psincdec", int'(bus.dcm_psincdec),   0);
    chk("midrst_busy",     int'(bus.cal_busy),       0);
    chk("midrst_done",     int'(bus.cal_done),       0);
    chk("midrst_bstart",   int'(bus.cal_best_start), 0);
    chk("midrst_blen",     int'(bus.cal_best_len),   0);
    repeat (2) @(posedge clk);
    #1 ctrl_reset = 1'b0;
    psen_snap = tot_psen;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_no_psen", tot_psen, psen_snap);
    chk("post_rst_idle",    int'(bus.cal_busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
